gpio_in_filter: RTL and testbench
=================================

# gpio_in_filter

Input-conditioning stage that sits between the GPIO pads and the `gpio` block's `gpio_di` input. Each pin is synchronized with two flops and debounced by a per-pin counter, and the filtered vector drives `gpio_di`. Rising and falling edges of the filtered value latch into a write-1-to-clear status register, which raises `irq`. Configuration uses the same memory-mapped command/response bus as the other peripherals.

## Interface
Parameters:
- NR_GPIOS, 8, number of pins (1..32)
- DB_W, 16, debounce counter / DEBOUNCE register width (1..32)
- DB_RST, 1000, reset value of DEBOUNCE (must fit in DB_W)

Ports:
- clk  in  1  system clock; the only clock
- reset_  in  1  reset, asynchronous, active-low
- mem_cmd_sel  in  1  block select
- mem_cmd_valid  in  1  command valid
- mem_cmd_wr  in  1  1 = write, 0 = read
- mem_cmd_addr  in  12  byte address; only [5:2] decoded
- mem_cmd_wdata  in  32  write data
- mem_rsp_rdata  out  32  read data, combinational
- mem_rsp_ready  out  1  read response valid, combinational
- pad_di  in  NR_GPIOS  raw asynchronous pad inputs
- gpio_di_filt  out  NR_GPIOS  debounced value; connects to `gpio.gpio_di`
- irq  out  1  level interrupt, equal to OR of STATUS

## Operation
- Register map (offset = {addr[5:2],2'b00}):
  - 0x00 DIN: read-only filtered value.
  - 0x04 RISE_EN: read/write.
  - 0x08 FALL_EN: read/write.
  - 0x0C STATUS: read; a write clears the bits that are 1 in the write data (W1C).
  - 0x10 DEBOUNCE: read/write, [DB_W-1:0].
  - Any other offset reads 0 and ignores writes.
  - Unused upper bits read 0.
- Write: occurs on the rising clk edge when valid && sel && wr.
- Read: when valid && sel && !wr, mem_rsp_ready=1 in the same cycle and rdata is selected combinationally. Otherwise rdata=0 and ready=0. Writes produce no ready.
- Synchronizer, per pin: s1 <= pad_di; s2 <= s1.
- Debounce, per pin, with filtered flop f and counter cnt[DB_W-1:0]:
  - If s2 == f: cnt <= 0.
  - Else if cnt >= DEBOUNCE: f <= s2 and cnt <= 0.
  - Else: cnt <= cnt + 1.
  - cnt never wraps, because the >= compare bounds it.
  - A glitch shorter than the threshold resets the count and never reaches f.
- gpio_di_filt = f, driven directly from the flops.
- Edge detect: f_d <= f.
  - rise = f & ~f_d & RISE_EN
  - fall = ~f & f_d & FALL_EN
  - STATUS <= (STATUS & ~w1c) | rise | fall
  - A set in the same cycle as a W1C clear of the same bit wins.
- Enable bits gate only new events. Clearing RISE_EN or FALL_EN does not clear STATUS.
- DEBOUNCE changes take effect on the next compare. Lowering it below an in-flight cnt causes an immediate update.
- Reset values: s1, s2, f, f_d, cnt, RISE_EN, FALL_EN and STATUS are 0; DEBOUNCE = DB_RST; irq = 0; gpio_di_filt = 0.
- A pin held high through reset release produces a rising edge once debounced. Software clears it after enabling.

## Timing
- Pad change to s2: 2 cycles.
- s2 differing from f to f updating: DEBOUNCE+1 cycles, provided s2 is stable.
- f update to STATUS bit set: 1 cycle. irq follows STATUS combinationally in the same cycle.
- Total pad-to-irq latency with DEBOUNCE = N: N+4 rising edges.
- reset_ is asserted asynchronously at any time and forces all state to its reset value immediately.
- Release of reset_ is synchronized externally.

## Test plan
- Reset: after reset, DEBOUNCE reads 1000 and DIN, STATUS, irq and gpio_di_filt are 0. A read at 0x14 returns 0 with ready=1.
- Debounce threshold:
  - Setup: DEBOUNCE=3, RISE_EN=0x01, pad_di[0] rises and is held.
  - Required: gpio_di_filt[0] rises exactly 6 edges after the pad change; STATUS=0x01 and irq=1 one edge later.
- Glitch rejection: DEBOUNCE=3, pad_di[2] is pulsed high for 3 cycles → DIN stays 0 and STATUS stays 0.
- Falling edge and W1C:
  - Setup: FALL_EN=0x80, pin 7 is debounced high then low → STATUS=0x80.
  - Write 0x00 to STATUS → STATUS stays 0x80.
  - Write 0x80 to STATUS → STATUS=0x00 and irq=0.
- Set/clear collision: a W1C write of bit 1 lands in the same cycle as a new rise on pin 1 → STATUS[1] stays 1.
- Edge cases:
  - DEBOUNCE=0: f follows s2 one cycle later.
  - Lowering DEBOUNCE from 100 to 5 while a count of 50 is in progress → f updates on the next edge.
  - reset_ asserted mid-count → cnt and f return to 0 and no status is set.

Source files
------------

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: input conditioning for the GPIO pads.
//
// Each pad is synchronised through two flops and debounced by a per-pin
// counter. The filtered value drives gpio_di_filt and is readable as DIN.
// Rising and falling edges of the filtered value, gated by RISE_EN and FALL_EN,
// latch into a write-1-to-clear STATUS register. irq is the OR of STATUS.
//
// Ports:
//   clk            system clock
//   reset_         asynchronous active-low reset
//   mem_cmd_*      command bus: sel, valid, wr, byte addr (only [5:2] decoded), wdata
//   mem_rsp_rdata  read data, combinational, zero unless a read is in progress
//   mem_rsp_ready  high in the same cycle as a read command; never for writes
//   pad_di         raw asynchronous pad inputs
//   gpio_di_filt   debounced pad value, straight from the filter flops
//   irq            level interrupt, OR of STATUS
//
// Register map (offset = {addr[5:2], 2'b00}):
//   0x00 DIN       RO   filtered value
//   0x04 RISE_EN   RW
//   0x08 FALL_EN   RW
//   0x0C STATUS    R/W1C
//   0x10 DEBOUNCE  RW   [DB_W-1:0]
//   others read 0, writes ignored

module gpio_in_filter #(
  parameter int unsigned NR_GPIOS = 8,
  parameter int unsigned DB_W     = 16,
  parameter int unsigned DB_RST   = 1000
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                mem_cmd_sel,
  input  logic                mem_cmd_valid,
  input  logic                mem_cmd_wr,
  input  logic [11:0]         mem_cmd_addr,
  input  logic [31:0]         mem_cmd_wdata,
  output logic [31:0]         mem_rsp_rdata,
  output logic                mem_rsp_ready,
  input  logic [NR_GPIOS-1:0] pad_di,
  output logic [NR_GPIOS-1:0] gpio_di_filt,
  output logic                irq
);

  typedef enum logic [3:0] {
    RegDin      = 4'h0,
    RegRiseEn   = 4'h1,
    RegFallEn   = 4'h2,
    RegStatus   = 4'h3,
    RegDebounce = 4'h4
  } reg_idx_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NR_GPIOS-1:0] s1_q, s2_q;
  logic [NR_GPIOS-1:0] f_q, f_d;
  logic [NR_GPIOS-1:0] f_dly_q;
  logic [DB_W-1:0]     cnt_q [NR_GPIOS];
  logic [DB_W-1:0]     cnt_d [NR_GPIOS];

  logic [NR_GPIOS-1:0] rise_en_q, rise_en_d;
  logic [NR_GPIOS-1:0] fall_en_q, fall_en_d;
  logic [NR_GPIOS-1:0] status_q, status_d;
  logic [DB_W-1:0]     debounce_q, debounce_d;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  reg_idx_e reg_idx;
  logic     wr_en;
  logic     rd_en;

  assign reg_idx = reg_idx_e'(mem_cmd_addr[5:2]);
  assign wr_en   = mem_cmd_sel & mem_cmd_valid & mem_cmd_wr;
  assign rd_en   = mem_cmd_sel & mem_cmd_valid & ~mem_cmd_wr;

  // Address bits outside [5:2] and unused write-data bits are ignored.
  logic unused_bus;
  assign unused_bus = ^{mem_cmd_addr[11:6], mem_cmd_addr[1:0], mem_cmd_wdata};

  // ---------------------------------------------------------------------------
  // Debounce: a pin's counter runs only while s2 disagrees with f, and f takes
  // the new value once the count has reached DEBOUNCE. Any return of s2 to f
  // restarts the count, so short glitches never reach f. The >= compare makes
  // a lowered threshold take effect on the very next edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NR_GPIOS; i++) begin
      if (s2_q[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= debounce_q) begin
        f_d[i]   = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detect and STATUS. A new event is ORed in after the W1C mask, so a
  // set wins over a clear of the same bit in the same cycle.
  // ---------------------------------------------------------------------------
  logic [NR_GPIOS-1:0] rise, fall, w1c;

  assign rise = f_q & ~f_dly_q & rise_en_q;
  assign fall = ~f_q & f_dly_q & fall_en_q;
  assign w1c  = (wr_en && (reg_idx == RegStatus)) ? mem_cmd_wdata[NR_GPIOS-1:0] : '0;

  assign status_d = (status_q & ~w1c) | rise | fall;

  // ---------------------------------------------------------------------------
  // Configuration register writes
  // ---------------------------------------------------------------------------
  always_comb begin
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    debounce_d = debounce_q;
    if (wr_en) begin
      case (reg_idx)
        RegRiseEn:   rise_en_d  = mem_cmd_wdata[NR_GPIOS-1:0];
        RegFallEn:   fall_en_d  = mem_cmd_wdata[NR_GPIOS-1:0];
        RegDebounce: debounce_d = mem_cmd_wdata[DB_W-1:0];
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path (combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rsp_rdata = '0;
    mem_rsp_ready = rd_en;
    if (rd_en) begin
      case (reg_idx)
        RegDin:      mem_rsp_rdata[NR_GPIOS-1:0] = f_q;
        RegRiseEn:   mem_rsp_rdata[NR_GPIOS-1:0] = rise_en_q;
        RegFallEn:   mem_rsp_rdata[NR_GPIOS-1:0] = fall_en_q;
        RegStatus:   mem_rsp_rdata[NR_GPIOS-1:0] = status_q;
        RegDebounce: mem_rsp_rdata[DB_W-1:0]     = debounce_q;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s1_q       <= '0;
      s2_q       <= '0;
      f_q        <= '0;
      f_dly_q    <= '0;
      cnt_q      <= '{default: '0};
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      debounce_q <= DB_W'(DB_RST);
    end else begin
      s1_q       <= pad_di;
      s2_q       <= s1_q;
      f_q        <= f_d;
      f_dly_q    <= f_q;
      cnt_q      <= cnt_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      debounce_q <= debounce_d;
    end
  end

  assign gpio_di_filt = f_q;
  assign irq          = |status_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed testbench for gpio_in_filter. Inputs are driven on the falling
// edge; outputs are sampled 1 time unit after the rising edge or mid-phase.

module tb_gpio_in_filter;

  localparam logic [11:0] ADDR_DIN      = 12'h000;
  localparam logic [11:0] ADDR_RISE_EN  = 12'h004;
  localparam logic [11:0] ADDR_FALL_EN  = 12'h008;
  localparam logic [11:0] ADDR_STATUS   = 12'h00C;
  localparam logic [11:0] ADDR_DEBOUNCE = 12'h010;
  localparam logic [11:0] ADDR_UNMAPPED = 12'h014;

  logic        clk;
  logic        reset_;
  logic        mem_cmd_sel;
  logic        mem_cmd_valid;
  logic        mem_cmd_wr;
  logic [11:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_ready;
  logic [7:0]  pad_di;
  logic [7:0]  gpio_di_filt;
  logic        irq;

  int n_tests;
  int n_fail;

  gpio_in_filter #(
    .NR_GPIOS(8),
    .DB_W    (16),
    .DB_RST  (1000)
  ) u_dut (
    .clk          (clk),
    .reset_       (reset_),
    .mem_cmd_sel  (mem_cmd_sel),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_wr   (mem_cmd_wr),
    .mem_cmd_addr (mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_ready(mem_rsp_ready),
    .pad_di       (pad_di),
    .gpio_di_filt (gpio_di_filt),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write lands on the next rising edge; returns 1 unit after that edge.
  task automatic bus_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_cmd_sel   = 1'b1;
    mem_cmd_valid = 1'b1;
    mem_cmd_wr    = 1'b1;
    mem_cmd_addr  = addr;
    mem_cmd_wdata = data;
    @(posedge clk);
    #1;
    mem_cmd_sel   = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_wr    = 1'b0;
    mem_cmd_wdata = '0;
  endtask

  // Combinational read: no clock edge consumed. Call away from a rising edge.
  task automatic bus_read(input logic [11:0] addr, output logic [31:0] data,
                          output logic ready);
    mem_cmd_sel   = 1'b1;
    mem_cmd_valid = 1'b1;
    mem_cmd_wr    = 1'b0;
    mem_cmd_addr  = addr;
    #1;
    data          = mem_rsp_rdata;
    ready         = mem_rsp_ready;
    mem_cmd_sel   = 1'b0;
    mem_cmd_valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        r;
    bus_read(addr, d, r);
    check_eq(tag, d, exp);
  endtask

  // Bounded run time regardless of what the DUT does.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        r;

    n_tests       = 0;
    n_fail        = 0;
    reset_        = 1'b0;
    mem_cmd_sel   = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_wr    = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_wdata = '0;
    pad_di        = '0;

    // ---------------- Reset state ----------------
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    rd_check("rst_debounce", ADDR_DEBOUNCE, 32'd1000);
    rd_check("rst_din", ADDR_DIN, 32'h0);
    rd_check("rst_status", ADDR_STATUS, 32'h0);
    rd_check("rst_rise_en", ADDR_RISE_EN, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    check_eq("rst_filt", {24'b0, gpio_di_filt}, 32'h0);
    bus_read(ADDR_UNMAPPED, d, r);
    check_eq("unmapped_rdata", d, 32'h0);
    check_eq("unmapped_ready", {31'b0, r}, 32'h1);
    // A write must not raise ready.
    mem_cmd_sel = 1'b1; mem_cmd_valid = 1'b1; mem_cmd_wr = 1'b1;
    mem_cmd_addr = ADDR_UNMAPPED; mem_cmd_wdata = 32'hFFFF_FFFF;
    #1;
    check_eq("write_no_ready", {31'b0, mem_rsp_ready}, 32'h0);
    check_eq("write_rdata_zero", mem_rsp_rdata, 32'h0);
    mem_cmd_sel = 1'b0; mem_cmd_valid = 1'b0; mem_cmd_wr = 1'b0; mem_cmd_wdata = '0;

    // ---------------- Debounce threshold (DEBOUNCE=3) ----------------
    bus_write(ADDR_DEBOUNCE, 32'd3);
    bus_write(ADDR_RISE_EN, 32'h01);
    rd_check("debounce_rb", ADDR_DEBOUNCE, 32'd3);
    @(negedge clk);
    pad_di[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) check_eq("thr_filt_edge5", {31'b0, gpio_di_filt[0]}, 32'h0);
      if (k == 6) begin
        check_eq("thr_filt_edge6", {31'b0, gpio_di_filt[0]}, 32'h1);
        check_eq("thr_irq_edge6", {31'b0, irq}, 32'h0);
      end
      if (k == 7) begin
        check_eq("thr_irq_edge7", {31'b0, irq}, 32'h1);
        rd_check("thr_status_edge7", ADDR_STATUS, 32'h01);
      end
    end
    rd_check("thr_din", ADDR_DIN, 32'h01);
    bus_write(ADDR_STATUS, 32'h01);
    rd_check("thr_status_clr", ADDR_STATUS, 32'h0);

    // ---------------- Glitch rejection ----------------
    bus_write(ADDR_RISE_EN, 32'h07);
    @(negedge clk);
    pad_di[2] = 1'b1;
    repeat (3) @(negedge clk);
    pad_di[2] = 1'b0;
    repeat (10) @(negedge clk);
    rd_check("glitch_din", ADDR_DIN, 32'h01);
    rd_check("glitch_status", ADDR_STATUS, 32'h0);

    // ---------------- Falling edge and W1C ----------------
    bus_write(ADDR_FALL_EN, 32'h80);
    @(negedge clk);
    pad_di[7] = 1'b1;
    repeat (10) @(negedge clk);
    rd_check("fall_din_high", ADDR_DIN, 32'h81);
    rd_check("fall_rise_gated", ADDR_STATUS, 32'h0);
    pad_di[7] = 1'b0;
    repeat (10) @(negedge clk);
    rd_check("fall_status", ADDR_STATUS, 32'h80);
    check_eq("fall_irq", {31'b0, irq}, 32'h1);
    bus_write(ADDR_STATUS, 32'h00);
    rd_check("w1c_zero", ADDR_STATUS, 32'h80);
    bus_write(ADDR_STATUS, 32'h80);
    rd_check("w1c_clear", ADDR_STATUS, 32'h0);
    check_eq("w1c_irq", {31'b0, irq}, 32'h0);

    // ---------------- Set/clear collision on pin 1 ----------------
    @(negedge clk);
    pad_di[1] = 1'b1;
    repeat (6) @(posedge clk);
    // f[1] rose on edge 6; the rise latches on edge 7, same edge as this W1C.
    bus_write(ADDR_STATUS, 32'h02);
    rd_check("collide_status", ADDR_STATUS, 32'h02);
    bus_write(ADDR_STATUS, 32'h02);
    rd_check("collide_clear", ADDR_STATUS, 32'h0);

    // ---------------- DEBOUNCE = 0 ----------------
    bus_write(ADDR_DEBOUNCE, 32'd0);
    @(negedge clk);
    pad_di[3] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("db0_edge2", {31'b0, gpio_di_filt[3]}, 32'h0);
    @(posedge clk); #1;
    check_eq("db0_edge3", {31'b0, gpio_di_filt[3]}, 32'h1);

    // ---------------- Lower DEBOUNCE mid-count ----------------
    bus_write(ADDR_DEBOUNCE, 32'd100);
    @(negedge clk);
    pad_di[4] = 1'b1;
    repeat (52) @(posedge clk);
    // Count is 50 here; the write below lands on the next edge.
    bus_write(ADDR_DEBOUNCE, 32'd5);
    check_eq("lower_before", {31'b0, gpio_di_filt[4]}, 32'h0);
    @(posedge clk); #1;
    check_eq("lower_after", {31'b0, gpio_di_filt[4]}, 32'h1);

    // ---------------- Reset mid-count ----------------
    bus_write(ADDR_DEBOUNCE, 32'd10);
    bus_write(ADDR_RISE_EN, 32'hFF);
    bus_write(ADDR_STATUS, 32'hFF);
    rd_check("mid_pre_status", ADDR_STATUS, 32'h0);
    @(negedge clk);
    pad_di[5] = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    reset_ = 1'b0;
    #1;
    check_eq("async_rst_filt", {24'b0, gpio_di_filt}, 32'h0);
    check_eq("async_rst_irq", {31'b0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    repeat (15) @(negedge clk);
    rd_check("post_rst_status", ADDR_STATUS, 32'h0);
    rd_check("post_rst_debounce", ADDR_DEBOUNCE, 32'd1000);
    rd_check("post_rst_din", ADDR_DIN, 32'h0);
    check_eq("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
